// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for 8 requesters: holds a one-hot grant plus its encoded index until the owner releases.
// Optional forced release after MAX_HOLD cycles when compiled with ARB_TIMEOUT_EN defined.
module rr_encoder_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 3
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 16
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             valid_o,
    output logic             timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [N-1:0]     gnt_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic             valid_q;
    logic [IDX_W-1:0] ptr_q;

    logic             sel_found_d;
    logic [IDX_W-1:0] sel_idx_d;
    logic [IDX_W-1:0] scan_idx;

    // First set request at the smallest distance from ptr_q, wrapping modulo N.
    always_comb begin
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        scan_idx    = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = ptr_q + IDX_W'(i);
            if (!sel_found_d && req_i[scan_idx]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = scan_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [4:0] hold_q;
    logic       timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_found_d) begin
                        gnt_q     <= N'(1) << sel_idx_d;
                        gnt_idx_q <= sel_idx_d;
                        valid_q   <= 1'b1;
                        hold_q    <= '0;
                        state_q   <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req_i[gnt_idx_q] || (hold_q == 5'(MAX_HOLD - 1))) begin
                        // Released or forced off: owner drops to lowest priority next round.
                        gnt_q     <= '0;
                        valid_q   <= 1'b0;
                        ptr_q     <= gnt_idx_q + IDX_W'(1);
                        timeout_q <= req_i[gnt_idx_q];
                        state_q   <= IDLE;
                    end else begin
                        hold_q <= hold_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout_o = timeout_q;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel_found_d) begin
                        gnt_q     <= N'(1) << sel_idx_d;
                        gnt_idx_q <= sel_idx_d;
                        valid_q   <= 1'b1;
                        state_q   <= GRANT;
                    end
                end
                GRANT: begin
                    // Released: owner drops to lowest priority next round.
                    if (!req_i[gnt_idx_q]) begin
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        ptr_q   <= gnt_idx_q + IDX_W'(1);
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout_o = 1'b0;
`endif

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = gnt_idx_q;
    assign valid_o   = valid_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Randomized and directed bench for rr_encoder_arbiter against a queue-free behavioural model.
// Honours ARB_TIMEOUT_EN the same way the design does.
module tb_rr_encoder_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: current owner (-1 = none), rotation start, last granted index,
    // cycles the current grant has been visible, and the timeout pulse.
    int m_owner;
    int m_ptr;
    int m_last;
    int m_held;
    bit m_to;

    rr_encoder_arbiter dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .gnt_o    (gnt),
        .gnt_idx_o(gnt_idx),
        .valid_o  (valid),
        .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        for (int d = 0; d < 8; d++) begin
            if (r[(p + d) % 8]) return (p + d) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_last  = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r);
        int k;
        m_to = 1'b0;
        if (m_owner < 0) begin
            k = pick(r, m_ptr);
            if (k >= 0) begin
                m_owner = k;
                m_last  = k;
                m_held  = 1;
            end
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else if (TO_EN && m_held == MAX_HOLD) begin
            m_to    = 1'b1;
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else begin
            m_held++;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        check({tag, ".gnt"},     32'(gnt),     32'(eg));
        check({tag, ".idx"},     32'(gnt_idx), 32'(m_last));
        check({tag, ".valid"},   32'(valid),   32'(m_owner >= 0));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic cycle(input logic [7:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
        compare_all(tag);
    endtask

    // Asserts reset asynchronously from wherever we are in the cycle.
    task automatic do_reset(input logic [7:0] r);
        req   = r;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("rst_async");
        @(posedge clk);
        #1;
        compare_all("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int run;
        int to_cnt;
        logic [7:0] r;
        rst_n = 1'b0;
        req   = 8'hFF;
        model_reset();

        // 1: reset with all requesting, first grant to index 0
        do_reset(8'hFF);
        cycle(8'hFF, "t1");
        check("t1.first_gnt", 32'(gnt), 32'h01);
        $display("[TB] reset and first grant done");

        // 2: single-request walk
        for (int i = 0; i < 8; i++) begin
            r = 8'h01 << i;
            cycle(r, "t2");
            check("t2.walk_idx", 32'(gnt_idx), 32'(i));
            cycle(r, "t2");
            cycle(r, "t2");
            cycle(8'h00, "t2");
            check("t2.drop", 32'(valid), 32'(0));
            cycle(8'h00, "t2");
        end
        $display("[TB] single-request walk done");

        // 3: rotation with all requesting, including wrap 7->0
        do_reset(8'h00);
        for (int k = 0; k < 9; k++) begin
            cycle(8'hFF, "t3");
            check("t3.rot", 32'(gnt_idx), 32'(k % 8));
            cycle(8'hFF & ~(8'h01 << (k % 8)), "t3");
        end
        $display("[TB] rotation done");

        // 4: late requests ignored during grant, then served in rotation order
        do_reset(8'h00);
        cycle(8'h08, "t4");
        for (int k = 0; k < 3; k++) begin
            cycle(8'h4A, "t4");
            check("t4.hold", 32'(gnt), 32'h08);
        end
        cycle(8'h42, "t4");
        cycle(8'h42, "t4");
        check("t4.next6", 32'(gnt_idx), 32'd6);
        cycle(8'h02, "t4");
        cycle(8'h02, "t4");
        check("t4.next1", 32'(gnt_idx), 32'd1);
        $display("[TB] mid-grant requests done");

        // 5: reset during a grant, pointer back to 0
        cycle(8'h00, "t5");
        cycle(8'h20, "t5");
        cycle(8'h20, "t5");
        check("t5.own5", 32'(gnt_idx), 32'd5);
        #2;
        do_reset(8'h21);
        cycle(8'h21, "t5");
        check("t5.after_rst", 32'(gnt_idx), 32'd0);
        $display("[TB] reset mid-grant done");

        // 6: hold limit
        do_reset(8'h00);
        to_cnt = 0;
        cycle(8'h04, "t6");
        run = valid ? 1 : 0;
        for (int k = 0; k < 99; k++) begin
            cycle(8'h04, "t6");
            if (timeout) to_cnt++;
            if (!valid) break;
            run++;
        end
        check("t6.run", 32'(run), TO_EN ? 32'd16 : 32'd100);
        cycle(8'h04, "t6");
        if (timeout) to_cnt++;
        check("t6.regrant", 32'(gnt_idx), 32'd2);
        check("t6.valid", 32'(valid), 32'd1);
        check("t6.to_cnt", 32'(to_cnt), TO_EN ? 32'd1 : 32'd0);
        $display("[TB] hold limit done");

        // Random traffic, owner keeps requesting most of the time
        do_reset(8'h00);
        for (int k = 0; k < 3000; k++) begin
            r = 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            if ($urandom_range(0, 5) == 0) r = 8'h00;
            cycle(r, "rand");
            if ($urandom_range(0, 299) == 0) do_reset(8'($urandom));
        end
        $display("[TB] random traffic done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
